// File: rtl/input_filter_array.sv
// Multi-channel hit input filter: 2-FF sync, min-width glitch reject, one-cycle pulse, dead time, re-arm on low.
// Define INPUT_FILTER_STATS_EN to add saturating per-channel accepted/rejected hit counters (acc_cnt, rej_cnt).
module input_filter_array #(
  parameter int NCH       = 8,
  parameter int MIN_WIDTH = 2,
  parameter int DT_W      = 8,
  parameter int STAT_W    = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NCH-1:0]         hit,
  input  logic [NCH-1:0]         ch_enable,
  input  logic [DT_W-1:0]        dead_time,
  output logic [NCH-1:0]         filtered_hit,
  output logic                   valid,
  output logic [NCH-1:0]         stuck
`ifdef INPUT_FILTER_STATS_EN
  ,
  output logic [NCH*STAT_W-1:0]  acc_cnt,
  output logic [NCH*STAT_W-1:0]  rej_cnt
`endif
);

  // IDLE armed | QUALIFY width check | FIRE pulse | DEAD hold-off | WAIT_LOW await release
  typedef enum logic [2:0] {S_IDLE, S_QUALIFY, S_FIRE, S_DEAD, S_WAIT_LOW} state_e;

  logic [NCH-1:0] s1_q, hs_q;
  logic [NCH-1:0] fh_d, fh_q;
  logic [NCH-1:0] stuck_d, stuck_q;
  logic           valid_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q    <= '0;
      hs_q    <= '0;
      fh_q    <= '0;
      valid_q <= 1'b0;
      stuck_q <= '0;
    end else begin
      s1_q    <= hit;
      hs_q    <= s1_q;
      fh_q    <= fh_d;
      valid_q <= |fh_d;
      stuck_q <= stuck_d;
    end
  end

  assign filtered_hit = fh_q;
  assign valid        = valid_q;
  assign stuck        = stuck_q;

  for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
    state_e          state_q, state_d;
    logic [7:0]      wcnt_q, wcnt_d;
    logic [DT_W-1:0] dcnt_q, dcnt_d;
    logic [DT_W:0]   scnt_q, scnt_d;

    always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      dcnt_d  = dcnt_q;
      scnt_d  = '0;
      if (!ch_enable[ch]) begin
        state_d = S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (hs_q[ch]) begin
              wcnt_d  = 8'd1;
              state_d = (MIN_WIDTH == 1) ? S_FIRE : S_QUALIFY;
            end
          end
          S_QUALIFY: begin
            if (!hs_q[ch]) begin
              state_d = S_IDLE;
            end else begin
              wcnt_d = wcnt_q + 8'd1;
              if ({1'b0, wcnt_q} + 9'd1 == 9'(MIN_WIDTH)) state_d = S_FIRE;
            end
          end
          S_FIRE: begin
            dcnt_d  = dead_time;
            state_d = (dead_time != '0) ? S_DEAD : S_WAIT_LOW;
          end
          S_DEAD: begin
            if (dcnt_q <= DT_W'(1)) state_d = S_WAIT_LOW;
            else                    dcnt_d  = dcnt_q - DT_W'(1);
          end
          S_WAIT_LOW: begin
            // Saturates at 2^DT_W so a permanently stuck input keeps stuck asserted.
            if (!hs_q[ch]) state_d = S_IDLE;
            else           scnt_d  = scnt_q[DT_W] ? scnt_q : scnt_q + 1'b1;
          end
          default: state_d = S_IDLE;
        endcase
      end
    end

    assign fh_d[ch]    = (state_d == S_FIRE);
    assign stuck_d[ch] = scnt_d[DT_W];

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        state_q <= S_IDLE;
        wcnt_q  <= '0;
        dcnt_q  <= '0;
        scnt_q  <= '0;
      end else begin
        state_q <= state_d;
        wcnt_q  <= wcnt_d;
        dcnt_q  <= dcnt_d;
        scnt_q  <= scnt_d;
      end
    end

`ifdef INPUT_FILTER_STATS_EN
    logic [STAT_W-1:0] acc_q, rej_q;
    logic              rej_ev;

    assign rej_ev = ch_enable[ch] && (state_q == S_QUALIFY) && !hs_q[ch];

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        acc_q <= '0;
        rej_q <= '0;
      end else begin
        if (fh_d[ch] && !(&acc_q)) acc_q <= acc_q + 1'b1;
        if (rej_ev   && !(&rej_q)) rej_q <= rej_q + 1'b1;
      end
    end

    assign acc_cnt[ch*STAT_W +: STAT_W] = acc_q;
    assign rej_cnt[ch*STAT_W +: STAT_W] = rej_q;
`endif
  end

endmodule

// File: tb/tb_input_filter_array.sv
// Scoreboard bench for input_filter_array: run-length/hold-off reference model feeds expected pulses and stuck levels.
module tb_input_filter_array;
  localparam int NCH    = 8;
  localparam int MW     = 2;
  localparam int DT_W   = 8;
  localparam int STAT_W = 16;
  localparam int SAT    = 2**STAT_W - 1;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NCH-1:0]       hit = '0;
  logic [NCH-1:0]       ch_enable = '1;
  logic [DT_W-1:0]      dead_time = '0;
  logic [NCH-1:0]       filtered_hit, stuck;
  logic                 valid;
`ifdef INPUT_FILTER_STATS_EN
  logic [NCH*STAT_W-1:0] acc_cnt, rej_cnt;
`endif

  input_filter_array #(.NCH(NCH), .MIN_WIDTH(MW), .DT_W(DT_W), .STAT_W(STAT_W)) dut (
    .clk(clk), .rst_n(rst_n), .hit(hit), .ch_enable(ch_enable), .dead_time(dead_time),
    .filtered_hit(filtered_hit), .valid(valid), .stuck(stuck)
`ifdef INPUT_FILTER_STATS_EN
    , .acc_cnt(acc_cnt), .rej_cnt(rej_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int c; logic [NCH-1:0] v; } ev_t;
  ev_t pq[$];
  ev_t sq[$];
  int  vectors = 0;
  int  miscompares = 0;
  bit  mon_on = 0;
  int  mon_from = 0;

  // Reference model: a run of synchronised highs reaching MW fires once, then the
  // channel ignores input for dead_time cycles and waits for the input to go low.
  int  run[NCH], fire_at[NCH], dead_end[NCH], wcount[NCH], acc_m[NCH], rej_m[NCH];
  bit  blk[NCH];
  logic [NCH-1:0] m_s1 = '0, m_hs = '0;

  task automatic model(input int c, input logic [NCH-1:0] hin, input logic [NCH-1:0] en,
                       input logic [DT_W-1:0] dt, input logic rn);
    logic [NCH-1:0] fh, st;
    fh = '0;
    st = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      if (!rn) begin
        run[ch] = 0; blk[ch] = 0; wcount[ch] = 0; acc_m[ch] = 0; rej_m[ch] = 0;
      end else if (!en[ch]) begin
        run[ch] = 0; blk[ch] = 0; wcount[ch] = 0;
      end else if (blk[ch]) begin
        if (c == fire_at[ch]) begin
          dead_end[ch] = c + 1 + int'(dt);
        end else if (c >= dead_end[ch]) begin
          if (m_hs[ch]) begin
            wcount[ch]++;
            st[ch] = (wcount[ch] >= 2**DT_W);
          end else begin
            blk[ch] = 0;
            wcount[ch] = 0;
          end
        end
      end else if (m_hs[ch]) begin
        run[ch]++;
        if (run[ch] == MW) begin
          fh[ch] = 1'b1;
          run[ch] = 0;
          blk[ch] = 1;
          fire_at[ch] = c + 1;
          if (acc_m[ch] < SAT) acc_m[ch]++;
        end
      end else begin
        if (run[ch] > 0 && rej_m[ch] < SAT) rej_m[ch]++;
        run[ch] = 0;
      end
    end
    if (fh != '0) pq.push_back('{c + 1, fh});
    sq.push_back('{c + 1, st});
    if (!rn) begin
      m_s1 = '0;
      m_hs = '0;
    end else begin
      m_hs = m_s1;
      m_s1 = hin;
    end
  endtask

  task automatic step(input logic [NCH-1:0] h, input logic [NCH-1:0] en,
                      input logic [DT_W-1:0] dt, input logic rn);
    @(negedge clk);
    hit = h;
    ch_enable = en;
    dead_time = dt;
    rst_n = rn;
    if (!rn && !mon_on) begin
      mon_on = 1;
      mon_from = cyc + 1;
    end
    model(cyc, h, en, dt, rn);
  endtask

  always @(negedge clk) begin
    if (mon_on && cyc >= mon_from) begin
      while (pq.size() > 0 && pq[0].c < cyc) begin
        vectors++;
        miscompares++;
        $display("FAIL pulse_missing cyc=%0d got=none want=%b", pq[0].c, pq[0].v);
        void'(pq.pop_front());
      end
      if (valid !== 1'b0 || filtered_hit !== '0) begin
        vectors++;
        if (pq.size() > 0 && pq[0].c == cyc) begin
          if (filtered_hit !== pq[0].v || valid !== 1'b1) begin
            miscompares++;
            $display("FAIL pulse cyc=%0d got fh=%b valid=%b want fh=%b valid=1",
                     cyc, filtered_hit, valid, pq[0].v);
          end
          void'(pq.pop_front());
        end else begin
          miscompares++;
          $display("FAIL unexpected_pulse cyc=%0d got fh=%b valid=%b want none", cyc, filtered_hit, valid);
        end
      end
      while (sq.size() > 0 && sq[0].c < cyc) void'(sq.pop_front());
      if (sq.size() > 0 && sq[0].c == cyc) begin
        vectors++;
        if (stuck !== sq[0].v) begin
          miscompares++;
          $display("FAIL stuck cyc=%0d got=%b want=%b", cyc, stuck, sq[0].v);
        end
        void'(sq.pop_front());
      end
    end
  end

  localparam logic [NCH-1:0] ALL = '1;

  initial begin
    int rem[NCH];
    logic [NCH-1:0] lvl, ev;
    logic [DT_W-1:0] dtv;
    logic rnv;

    for (int ch = 0; ch < NCH; ch++) begin
      run[ch] = 0; blk[ch] = 0; wcount[ch] = 0; acc_m[ch] = 0; rej_m[ch] = 0;
      fire_at[ch] = 0; dead_end[ch] = 0; rem[ch] = 0;
    end

    // reset then quiet inputs
    for (int i = 0; i < 3; i++) step('0, ALL, 8'd4, 1'b0);
    for (int i = 0; i < 20; i++) step('0, ALL, 8'd4, 1'b1);

    // ch0 long pulse; ch1 one-cycle glitch
    for (int i = 0; i < 16; i++) step((i < 6) ? NCH'(1) : '0, ALL, 8'd4, 1'b1);
    for (int i = 0; i < 10; i++) step((i < 1) ? NCH'(2) : '0, ALL, 8'd4, 1'b1);

    // ch2 re-hit inside dead time, then after re-arm
    for (int i = 0; i < 24; i++)
      step((i < 2 || i == 3 || i == 4 || (i >= 12 && i < 15)) ? NCH'(4) : '0, ALL, 8'd4, 1'b1);

    // ch3 stuck high, release, re-arm
    for (int i = 0; i < 300; i++) step(NCH'(8), ALL, 8'd4, 1'b1);
    for (int i = 0; i < 10; i++) step('0, ALL, 8'd4, 1'b1);
    for (int i = 0; i < 10; i++) step((i < 3) ? NCH'(8) : '0, ALL, 8'd4, 1'b1);

    // ch4+ch5 together, ch5 disabled during qualification, reset while ch4 dead
    for (int i = 0; i < 12; i++)
      step((i < 4) ? NCH'(8'h30) : '0, (i >= 2 && i <= 5) ? ~NCH'(8'h20) : ALL, 8'd4, (i != 6));

    // randomized traffic
    lvl = '0;
    dtv = 8'd4;
    for (int i = 0; i < 3000; i++) begin
      for (int ch = 0; ch < NCH; ch++) begin
        if (rem[ch] == 0) begin
          lvl[ch] = ~lvl[ch];
          rem[ch] = ($urandom_range(0, 9) == 0) ? int'($urandom_range(5, 20)) : int'($urandom_range(1, 4));
        end
        rem[ch]--;
      end
      ev = ALL;
      for (int ch = 0; ch < NCH; ch++) if ($urandom_range(0, 99) == 0) ev[ch] = 1'b0;
      if ($urandom_range(0, 49) == 0) dtv = DT_W'($urandom_range(0, 7));
      rnv = ($urandom_range(0, 999) != 0);
      step(lvl, ev, dtv, rnv);
    end

    for (int i = 0; i < 12; i++) step('0, ALL, dtv, 1'b1);
    @(negedge clk);
    @(negedge clk);

    vectors++;
    if (pq.size() != 0) begin
      miscompares++;
      $display("FAIL pending_pulses got=%0d want=0", pq.size());
    end
`ifdef INPUT_FILTER_STATS_EN
    for (int ch = 0; ch < NCH; ch++) begin
      vectors += 2;
      if (acc_cnt[ch*STAT_W +: STAT_W] !== STAT_W'(acc_m[ch])) begin
        miscompares++;
        $display("FAIL acc_cnt[%0d] got=%0d want=%0d", ch, acc_cnt[ch*STAT_W +: STAT_W], acc_m[ch]);
      end
      if (rej_cnt[ch*STAT_W +: STAT_W] !== STAT_W'(rej_m[ch])) begin
        miscompares++;
        $display("FAIL rej_cnt[%0d] got=%0d want=%0d", ch, rej_cnt[ch*STAT_W +: STAT_W], rej_m[ch]);
      end
    end
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
